// File: rtl/ecc_pkg.sv
// ecc_pkg: shared width defaults, point-multiply controller state encoding and
// secp256k1 domain constants (field prime p and base point G).
package ecc_pkg;

  localparam int unsigned KEY_W_DEF = 256;
  localparam int unsigned CRD_W_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    DBL,
    DBL_W,
    ADD,
    ADD_W,
    FIN
  } pm_state_t;

  localparam logic [255:0] SECP_P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] SECP_GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] SECP_GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

endpackage

// File: rtl/point_mul_ctrl.sv
// point_mul_ctrl: left-to-right double-and-add scalar multiply sequencer driving an
// external point_add. Define POINT_MUL_CONST_TIME_EN to issue an ADD for every key bit.
module point_mul_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF,
  parameter int unsigned CRD_W = CRD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] k,
  input  logic [CRD_W-1:0] gx,
  input  logic [CRD_W-1:0] gy,
  output logic             busy,
  output logic             done,
  output logic [CRD_W-1:0] qx,
  output logic [CRD_W-1:0] qy,
  output logic             qinf,
  output logic             pa_start,
  output logic [CRD_W-1:0] pa_x1,
  output logic [CRD_W-1:0] pa_y1,
  output logic [CRD_W-1:0] pa_x2,
  output logic [CRD_W-1:0] pa_y2,
  output logic             pa_inf1,
  output logic             pa_inf2,
  input  logic             pa_done,
  input  logic [CRD_W-1:0] pa_x3,
  input  logic [CRD_W-1:0] pa_y3,
  input  logic             pa_inf3
);

  localparam int unsigned     IDX_W   = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);

  pm_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [CRD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [CRD_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic             rinf_q, rinf_d;
  logic [CRD_W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic             qinf_q, qinf_d, done_q, done_d;
  logic             pa_start_q, pa_start_d;
  logic [CRD_W-1:0] pa_x1_q, pa_x1_d, pa_y1_q, pa_y1_d;
  logic [CRD_W-1:0] pa_x2_q, pa_x2_d, pa_y2_q, pa_y2_d;
  logic             pa_inf1_q, pa_inf1_d, pa_inf2_q, pa_inf2_d;
  logic             bit_cur, last_bit;

  assign bit_cur  = k_q[idx_q];
  assign last_bit = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rinf_d  = rinf_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    qinf_d  = qinf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          gx_d    = gx;
          gy_d    = gy;
          rx_d    = '0;
          ry_d    = '0;
          rinf_d  = 1'b1;
          idx_d   = IDX_TOP;
          state_d = DBL;
        end
      end
      DBL: state_d = DBL_W;
      DBL_W: begin
        if (pa_done) begin
          rx_d   = pa_x3;
          ry_d   = pa_y3;
          rinf_d = pa_inf3;
`ifdef POINT_MUL_CONST_TIME_EN
          state_d = ADD;
`else
          if (bit_cur) begin
            state_d = ADD;
          end else if (last_bit) begin
            state_d = FIN;
          end else begin
            state_d = DBL;
            idx_d   = idx_q - IDX_W'(1);
          end
`endif
        end
      end
      ADD: state_d = ADD_W;
      ADD_W: begin
        if (pa_done) begin
`ifdef POINT_MUL_CONST_TIME_EN
          // Dummy add for a zero bit: the sum is computed but discarded.
          if (bit_cur) begin
            rx_d   = pa_x3;
            ry_d   = pa_y3;
            rinf_d = pa_inf3;
          end
`else
          rx_d   = pa_x3;
          ry_d   = pa_y3;
          rinf_d = pa_inf3;
`endif
          if (last_bit) begin
            state_d = FIN;
          end else begin
            state_d = DBL;
            idx_d   = idx_q - IDX_W'(1);
          end
        end
      end
      FIN: begin
        qx_d    = rinf_q ? '0 : rx_q;
        qy_d    = rinf_q ? '0 : ry_q;
        qinf_d  = rinf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are registered on entry to DBL/ADD so they are valid with pa_start
  // and held untouched through the following wait state.
  always_comb begin
    pa_start_d = 1'b0;
    pa_x1_d    = pa_x1_q;
    pa_y1_d    = pa_y1_q;
    pa_x2_d    = pa_x2_q;
    pa_y2_d    = pa_y2_q;
    pa_inf1_d  = pa_inf1_q;
    pa_inf2_d  = pa_inf2_q;
    case (state_d)
      DBL: begin
        pa_start_d = 1'b1;
        pa_x1_d    = rx_d;
        pa_y1_d    = ry_d;
        pa_inf1_d  = rinf_d;
        pa_x2_d    = rx_d;
        pa_y2_d    = ry_d;
        pa_inf2_d  = rinf_d;
      end
      ADD: begin
        pa_start_d = 1'b1;
        pa_x1_d    = rx_d;
        pa_y1_d    = ry_d;
        pa_inf1_d  = rinf_d;
        pa_x2_d    = gx_q;
        pa_y2_d    = gy_q;
        pa_inf2_d  = 1'b0;
      end
      DBL_W, ADD_W: ;
      default: begin
        pa_x1_d   = '0;
        pa_y1_d   = '0;
        pa_x2_d   = '0;
        pa_y2_d   = '0;
        pa_inf1_d = 1'b0;
        pa_inf2_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      k_q        <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rinf_q     <= 1'b1;
      qx_q       <= '0;
      qy_q       <= '0;
      qinf_q     <= 1'b1;
      done_q     <= 1'b0;
      pa_start_q <= 1'b0;
      pa_x1_q    <= '0;
      pa_y1_q    <= '0;
      pa_x2_q    <= '0;
      pa_y2_q    <= '0;
      pa_inf1_q  <= 1'b0;
      pa_inf2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rinf_q     <= rinf_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      qinf_q     <= qinf_d;
      done_q     <= done_d;
      pa_start_q <= pa_start_d;
      pa_x1_q    <= pa_x1_d;
      pa_y1_q    <= pa_y1_d;
      pa_x2_q    <= pa_x2_d;
      pa_y2_q    <= pa_y2_d;
      pa_inf1_q  <= pa_inf1_d;
      pa_inf2_q  <= pa_inf2_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign qx       = qx_q;
  assign qy       = qy_q;
  assign qinf     = qinf_q;
  assign pa_start = pa_start_q;
  assign pa_x1    = pa_x1_q;
  assign pa_y1    = pa_y1_q;
  assign pa_x2    = pa_x2_q;
  assign pa_y2    = pa_y2_q;
  assign pa_inf1  = pa_inf1_q;
  assign pa_inf2  = pa_inf2_q;

endmodule

// File: tb/tb_point_mul_ctrl.sv
// tb_point_mul_ctrl: drives point_mul_ctrl with a behavioural secp256k1 point_add
// and scores results and start-to-done latency through a queue scoreboard.
module tb_point_mul_ctrl;
  import ecc_pkg::*;

  localparam int unsigned KEY_W  = 256;
  localparam int unsigned CRD_W  = 256;
  localparam int          PA_LAT = 3;

  localparam logic [255:0] G2X = 256'h4A991F7C44E0C3796364193ADBB82DD47964B6431C79A9A3685CA2423C373ACF;
  localparam logic [255:0] G2Y = 256'h605EECCB3BFDABDAFF7916274EFB8C992F8F52BCF1BA318BDDBB60915B94D755;
  localparam logic [255:0] Q2X = 256'hF015694A1F7E48E1481CE48190CE72A8FF0CD85E3093274588EB8D46291222CC;
  localparam logic [255:0] Q2Y = 256'h2618750BD614F01D5787BD5CDD4392880F5D929404145EC80DFDA85C03481C8C;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [KEY_W-1:0] k;
  logic [CRD_W-1:0] gx, gy, qx, qy;
  logic             busy, done, qinf, pa_start, pa_inf1, pa_inf2;
  logic [CRD_W-1:0] pa_x1, pa_y1, pa_x2, pa_y2;
  logic             pa_done = 1'b0;
  logic [CRD_W-1:0] pa_x3 = '0, pa_y3 = '0;
  logic             pa_inf3 = 1'b0;

  point_mul_ctrl #(.KEY_W(KEY_W), .CRD_W(CRD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .gx(gx), .gy(gy),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .qinf(qinf),
    .pa_start(pa_start), .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_x2(pa_x2), .pa_y2(pa_y2),
    .pa_inf1(pa_inf1), .pa_inf2(pa_inf2),
    .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    logic         inf;
    int           cyc;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, done_cnt = 0, pa_cnt = 0, op_bad = 0, pulse_bad = 0;

  // ---------------- secp256k1 field / group model ----------------
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, SECP_P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, SECP_P}) t = t - {1'b0, SECP_P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? (a - b) : (a - b + SECP_P);
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] a);
    logic [255:0] r, e;
    r = 256'd1;
    e = SECP_P - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  task automatic ec_add(input logic [255:0] x1, y1, input logic i1,
                        input logic [255:0] x2, y2, input logic i2,
                        output logic [255:0] x3, y3, output logic i3);
    logic [255:0] lam;
    if (i1) begin
      x3 = x2; y3 = y2; i3 = i2;
    end else if (i2) begin
      x3 = x1; y3 = y1; i3 = i1;
    end else if (x1 == x2) begin
      if (y1 != y2 || y1 == 256'd0) begin
        x3 = '0; y3 = '0; i3 = 1'b1;
      end else begin
        lam = fmul(fmul(256'd3, fmul(x1, x1)), finv(fadd(y1, y1)));
        x3  = fsub(fmul(lam, lam), fadd(x1, x1));
        y3  = fsub(fmul(lam, fsub(x1, x3)), y1);
        i3  = 1'b0;
      end
    end else begin
      lam = fmul(fsub(y2, y1), finv(fsub(x2, x1)));
      x3  = fsub(fsub(fmul(lam, lam), x1), x2);
      y3  = fsub(fmul(lam, fsub(x1, x3)), y1);
      i3  = 1'b0;
    end
  endtask

  function automatic int exp_lat(input logic [KEY_W-1:0] kk);
    int n;
`ifdef POINT_MUL_CONST_TIME_EN
    n = 2 * KEY_W;
`else
    n = KEY_W;
    for (int i = 0; i < KEY_W; i++) n += int'(kk[i]);
`endif
    return 2 + n * (PA_LAT + 1);
  endfunction

  // ---------------- behavioural point_add (not reset: stale results can arrive) ----------------
  logic [255:0] lx1, ly1, lx2, ly2, rx, ry;
  logic         li1, li2, ri;
  int           pa_cntdown = 0;
  bit           pa_pend = 0, pa_prev = 0;

  always @(negedge clk) begin
    pa_done = 1'b0;
    if (pa_pend) begin
      if (busy && !pa_start &&
          (pa_x1 !== lx1 || pa_y1 !== ly1 || pa_x2 !== lx2 || pa_y2 !== ly2 ||
           pa_inf1 !== li1 || pa_inf2 !== li2)) op_bad++;
      pa_cntdown--;
      if (pa_cntdown == 0) begin
        pa_x3 = rx; pa_y3 = ry; pa_inf3 = ri;
        pa_done = 1'b1;
        pa_pend = 0;
      end
    end
    if (pa_start === 1'b1) begin
      lx1 = pa_x1; ly1 = pa_y1; li1 = pa_inf1;
      lx2 = pa_x2; ly2 = pa_y2; li2 = pa_inf2;
      ec_add(lx1, ly1, li1, lx2, ly2, li2, rx, ry, ri);
      pa_cntdown = PA_LAT;
      pa_pend    = 1;
      pa_cnt++;
      if (pa_prev) pulse_bad++;
    end
    pa_prev = (pa_start === 1'b1);
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      got_q.push_back('{x: qx, y: qy, inf: qinf, cyc: cyc});
      done_cnt++;
    end
  end

  always @(posedge clk) cyc++;

  task automatic drive_start(input logic [KEY_W-1:0] kk, input logic [255:0] gxx, gyy,
                             output int sc);
    @(posedge clk); #1;
    k = kk; gx = gxx; gy = gyy; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if (got_q.size() > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pa_start !== 1'b0) begin failures++; $display("FAIL reset_pa_start got=%b exp=0", pa_start); end
    checks++; if (qinf !== 1'b1) begin failures++; $display("FAIL reset_qinf got=%b exp=1", qinf); end
    checks++; if (qx !== '0 || qy !== '0) begin failures++; $display("FAIL reset_q got=%h,%h exp=0", qx, qy); end
    checks++;
    if (pa_x1 !== '0 || pa_y1 !== '0 || pa_x2 !== '0 || pa_y2 !== '0 || pa_inf1 !== 1'b0 || pa_inf2 !== 1'b0) begin
      failures++; $display("FAIL reset_pa_ops got x1=%h inf1=%b inf2=%b exp=0", pa_x1, pa_inf1, pa_inf2);
    end
  endtask

  task automatic test_mul(input string name, input logic [KEY_W-1:0] kk, input logic [255:0] gxx, gyy,
                          input logic [255:0] ex, ey, input logic einf);
    int sc; bit ok; res_t e, g;
    drive_start(kk, gxx, gyy, sc);
    exp_q.push_back('{x: ex, y: ey, inf: einf, cyc: sc + exp_lat(kk)});
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL %s_timeout got=no_done exp=done", name);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    g = got_q.pop_front();
    checks++; if (g.x !== e.x) begin failures++; $display("FAIL %s_qx got=%h exp=%h", name, g.x, e.x); end
    checks++; if (g.y !== e.y) begin failures++; $display("FAIL %s_qy got=%h exp=%h", name, g.y, e.y); end
    checks++; if (g.inf !== e.inf) begin failures++; $display("FAIL %s_qinf got=%b exp=%b", name, g.inf, e.inf); end
    checks++;
    if (g.cyc - sc != e.cyc - sc) begin
      failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, g.cyc - sc, e.cyc - sc);
    end
  endtask

  task automatic test_back_to_back();
    int sc, d0; bit ok; res_t e, g;
    d0 = done_cnt;
    drive_start(KEY_W'(1), SECP_GX, SECP_GY, sc);
    exp_q.push_back('{x: SECP_GX, y: SECP_GY, inf: 1'b0, cyc: sc + exp_lat(KEY_W'(1))});
    repeat (4) @(posedge clk);
    #1; k = KEY_W'(2); gx = G2X; gy = G2Y; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_timeout got=no_done exp=done");
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    g = got_q.pop_front();
    checks++;
    if (g.x !== e.x || g.y !== e.y || g.inf !== e.inf) begin
      failures++; $display("FAIL b2b_result got=%h,%h,%b exp=%h,%h,%b", g.x, g.y, g.inf, e.x, e.y, e.inf);
    end
    checks++; if (g.cyc != e.cyc) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", g.cyc - sc, e.cyc - sc); end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_abort();
    int sc, p0; bit hit;
    hit = 0;
    drive_start(KEY_W'(3), SECP_GX, SECP_GY, sc);
    p0 = pa_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (pa_cnt - p0 >= 100) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_reach_iter got=%0d exp=100", pa_cnt - p0); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (qinf !== 1'b1) begin failures++; $display("FAIL abort_qinf got=%b exp=1", qinf); end
    checks++; if (qx !== '0 || qy !== '0) begin failures++; $display("FAIL abort_q got=%h,%h exp=0", qx, qy); end
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_operand_hold();
    checks++; if (op_bad != 0) begin failures++; $display("FAIL operand_hold got=%0d exp=0", op_bad); end
    checks++; if (pulse_bad != 0) begin failures++; $display("FAIL pa_start_pulse got=%0d exp=0", pulse_bad); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stray_done got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    logic [255:0] dx, dy, tx, ty;
    logic         di, ti;
    rst_n = 1'b0; start = 1'b0; k = '0; gx = '0; gy = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_mul("k1", KEY_W'(1), SECP_GX, SECP_GY, SECP_GX, SECP_GY, 1'b0);
    test_mul("k2", KEY_W'(2), G2X, G2Y, Q2X, Q2Y, 1'b0);
    test_mul("k0", KEY_W'(0), SECP_GX, SECP_GY, '0, '0, 1'b1);
    ec_add(SECP_GX, SECP_GY, 1'b0, SECP_GX, SECP_GY, 1'b0, dx, dy, di);
    ec_add(dx, dy, di, SECP_GX, SECP_GY, 1'b0, tx, ty, ti);
    test_mul("k3", KEY_W'(3), SECP_GX, SECP_GY, tx, ty, ti);
    test_back_to_back();
    test_reset_abort();
    test_mul("post_reset_k1", KEY_W'(1), SECP_GX, SECP_GY, SECP_GX, SECP_GY, 1'b0);
    test_operand_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
